// File: rtl/coin_pkg.sv
// coin_pkg: shared definitions for the coin input front end.
//   coin_code_e  - 2-bit code stored in the coin queue
//   VALUE_*      - credit value of each coin
//   coin_value() - code to credit value
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2
    } coin_code_e;

    localparam int unsigned VALUE_NICKEL  = 5;
    localparam int unsigned VALUE_DIME    = 10;
    localparam int unsigned VALUE_QUARTER = 25;

    function automatic int unsigned coin_value(coin_code_e code);
        case (code)
            COIN_NICKEL:  return VALUE_NICKEL;
            COIN_DIME:    return VALUE_DIME;
            COIN_QUARTER: return VALUE_QUARTER;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-FF synchroniser, stability counter and rising-edge
// event for a single raw sensor/button line.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   raw                : asynchronous input line
//   rise               : one-cycle pulse when the debounced level goes 0->1
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic raw,
    output logic rise
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2, level;
    logic [CW-1:0] cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle of
    // disagreement; rise is registered alongside the flip.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    rise  <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounces coin sensors and the cancel button,
// queues accepted coins and paces single-cycle pulses to the vending FSM.
//   sys_clk, sys_rst_n      : clock, asynchronous active-low reset
//   coin_*_raw, cancel_raw  : raw asynchronous lines
//   ready                   : downstream can take a coin pulse this cycle
//   nickel/dime/quarter     : one-cycle credit pulses (mutually exclusive)
//   cancel                  : one-cycle cancel pulse
//   coin_reject             : one-cycle diverter pulse for uncredited coins
//   fifo_level              : number of queued coins
// Optional (macro COIN_INPUT_COUNT_EN): cnt_nickel/dime/quarter/reject,
// 16-bit saturating pulse counters cleared only by reset.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000,
    parameter int unsigned GAP_CYCLES      = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          coin_nickel_raw,
    input  logic                          coin_dime_raw,
    input  logic                          coin_quarter_raw,
    input  logic                          cancel_raw,
    input  logic                          ready,
    output logic                          nickel,
    output logic                          dime,
    output logic                          quarter,
    output logic                          cancel,
    output logic                          coin_reject,
`ifdef COIN_INPUT_COUNT_EN
    output logic [15:0]                   cnt_nickel,
    output logic [15:0]                   cnt_dime,
    output logic [15:0]                   cnt_quarter,
    output logic [15:0]                   cnt_reject,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    logic ev_nickel, ev_dime, ev_quarter, ev_cancel;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nickel (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw(coin_nickel_raw), .rise(ev_nickel));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dime (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw(coin_dime_raw), .rise(ev_dime));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_quarter (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw(coin_quarter_raw), .rise(ev_quarter));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw(cancel_raw), .rise(ev_cancel));

    // pend/grant are indexed by coin code: [0]=nickel [1]=dime [2]=quarter
    logic [2:0]    pend, grant;
    coin_code_e    push_code, head;
    coin_code_e    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap;
    logic          empty, full, pop, push, drop, flushed;
    logic          nx_nickel, nx_dime, nx_quarter, nx_cancel, nx_reject;

    always_comb begin
        grant     = 3'b000;
        push_code = COIN_NICKEL;
        if (pend[2]) begin
            grant = 3'b100; push_code = COIN_QUARTER;
        end else if (pend[1]) begin
            grant = 3'b010; push_code = COIN_DIME;
        end else if (pend[0]) begin
            grant = 3'b001; push_code = COIN_NICKEL;
        end
        empty = (fifo_level == '0);
        full  = (fifo_level == LW'(FIFO_DEPTH));
        head  = fifo_mem[rd_ptr];
        // cancel wins over everything queued this cycle
        pop   = !empty && ready && (gap == '0) && !ev_cancel;
        push  = (|pend) && (!full || pop) && !ev_cancel;
        drop  = (|pend) && full && !pop && !ev_cancel;
        // coins arriving alongside a cancel are discarded too, so they count
        flushed    = !empty || (|pend) || ev_nickel || ev_dime || ev_quarter;
        nx_nickel  = pop && (head == COIN_NICKEL);
        nx_dime    = pop && (head == COIN_DIME);
        nx_quarter = pop && (head == COIN_QUARTER);
        nx_cancel  = ev_cancel;
        nx_reject  = ev_cancel ? flushed : drop;
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            gap         <= '0;
            nickel      <= 1'b0;
            dime        <= 1'b0;
            quarter     <= 1'b0;
            cancel      <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            nickel      <= nx_nickel;
            dime        <= nx_dime;
            quarter     <= nx_quarter;
            cancel      <= nx_cancel;
            coin_reject <= nx_reject;
            if (ev_cancel) begin
                pend       <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                gap        <= '0;
            end else begin
                // the granted bit is consumed whether pushed or dropped
                pend <= (pend & ~grant) | {ev_quarter, ev_dime, ev_nickel};
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + LW'(1);
                    2'b01:   fifo_level <= fifo_level - LW'(1);
                    default: fifo_level <= fifo_level;
                endcase
                if (pop)
                    gap <= GW'(GAP_CYCLES);
                else if (gap != '0)
                    gap <= gap - GW'(1);
            end
        end
    end

`ifdef COIN_INPUT_COUNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_nickel  <= '0;
            cnt_dime    <= '0;
            cnt_quarter <= '0;
            cnt_reject  <= '0;
        end else begin
            if (nx_nickel  && cnt_nickel  != 16'hFFFF) cnt_nickel  <= cnt_nickel  + 16'd1;
            if (nx_dime    && cnt_dime    != 16'hFFFF) cnt_dime    <= cnt_dime    + 16'd1;
            if (nx_quarter && cnt_quarter != 16'hFFFF) cnt_quarter <= cnt_quarter + 16'd1;
            if (nx_reject  && cnt_reject  != 16'hFFFF) cnt_reject  <= cnt_reject  + 16'd1;
        end
    end
`endif

endmodule
